// File: rtl/me_sad_accum.sv
// me_sad_accum: row-serial SAD accumulator and candidate sequencer.
// Sums ROWS row SADs per search candidate, presents each full-block SAD with
// its (x, y) position to the min-SAD comparator, and walks the search window
// in raster order.
// Optional early termination: define SAD_EARLY_TERM_EN to abandon a candidate
// as soon as its partial sum reaches the comparator's current best.
module me_sad_accum #(
    parameter int ROWS   = 16,
    parameter int X_LAST = 32,
    parameter int Y_LAST = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] row_sad,
    input  logic        row_valid,
    output logic        row_ready,
    input  logic [15:0] min_sad,
    output logic        reset_sum,
    output logic        comp_en,
    output logic [15:0] sad,
    output logic [5:0]  addr,
    output logic [5:0]  amt,
    output logic        cand_skip,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0] X_END    = 6'(X_LAST);
    localparam logic [5:0] Y_END    = 6'(Y_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_EMIT,
        S_SKIP,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_acc;
    logic [4:0]  r_row;
    logic [5:0]  r_x;
    logic [5:0]  r_y;

    logic [15:0] w_sum;
    logic        w_accept;
    logic        w_last_row;
    logic        w_last_cand;
    logic        w_early;

    logic        r_reset_sum;
    logic        r_comp_en;
    logic        r_cand_skip;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_sad;
    logic [5:0]  r_addr;
    logic [5:0]  r_amt;

    // The running sum cannot wrap: ROWS rows of at most 4080 fit in 16 bits.
    assign w_sum       = r_acc + {4'd0, row_sad};
    assign w_last_row  = (r_row == LAST_ROW);
    assign w_last_cand = (r_x == X_END) && (r_y == Y_END);
    assign w_accept    = (r_state == S_ACCUM) && row_valid;

`ifdef SAD_EARLY_TERM_EN
    assign w_early = (w_sum >= min_sad);
`else
    logic w_unused_min_sad;
    assign w_unused_min_sad = ^min_sad;
    assign w_early          = 1'b0;
`endif

    // State register; reset discards any search in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one candidate is ROWS accepted rows then EMIT or SKIP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_accept) begin
                    if (w_last_row) begin
                        w_next = S_EMIT;
                    end else if (w_early) begin
                        w_next = S_SKIP;
                    end
                end
            end
            S_EMIT, S_SKIP: begin
                w_next = w_last_cand ? S_DONE : S_ACCUM;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; strobes are decoded from the next state
    // so they line up with the cycle spent in the corresponding state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_row       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_reset_sum <= 1'b0;
            r_comp_en   <= 1'b0;
            r_cand_skip <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sad       <= '0;
            r_addr      <= '0;
            r_amt       <= '0;
        end else begin
            r_reset_sum <= (w_next == S_CLEAR);
            r_comp_en   <= (w_next == S_EMIT);
            r_cand_skip <= (w_next == S_SKIP);
            r_done      <= (w_next == S_DONE);
            r_busy      <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    r_row <= '0;
                    r_x   <= '0;
                    r_y   <= '0;
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_row <= r_row + 5'd1;
                        if (w_next == S_EMIT) begin
                            r_sad  <= w_sum;
                            r_addr <= r_x;
                            r_amt  <= r_y;
                        end
                    end
                end
                S_EMIT, S_SKIP: begin
                    r_acc <= '0;
                    r_row <= '0;
                    if (r_x == X_END) begin
                        r_x <= '0;
                        r_y <= r_y + 6'd1;
                    end else begin
                        r_x <= r_x + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign row_ready = (r_state == S_ACCUM);
    assign reset_sum = r_reset_sum;
    assign comp_en   = r_comp_en;
    assign cand_skip = r_cand_skip;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sad       = r_sad;
    assign addr      = r_addr;
    assign amt       = r_amt;

endmodule

// File: tb/tb_me_sad_accum.sv
// tb_me_sad_accum: directed bench for me_sad_accum on a 2x2 search window.
module tb_me_sad_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] row_sad;
    logic        row_valid;
    logic        row_ready;
    logic [15:0] min_sad;
    logic        reset_sum;
    logic        comp_en;
    logic [15:0] sad;
    logic [5:0]  addr;
    logic [5:0]  amt;
    logic        cand_skip;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    me_sad_accum #(
        .ROWS   (16),
        .X_LAST (1),
        .Y_LAST (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .row_sad   (row_sad),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .min_sad   (min_sad),
        .reset_sum (reset_sum),
        .comp_en   (comp_en),
        .sad       (sad),
        .addr      (addr),
        .amt       (amt),
        .cand_skip (cand_skip),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        start     = 1'b0;
        row_valid = 1'b0;
        row_sad   = '0;
        min_sad   = 16'hFFFF;
        repeat (3) tick();
        n_checks++;
        if ({row_ready, reset_sum, comp_en, cand_skip, busy, done} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: got %b want 000000",
                     {row_ready, reset_sum, comp_en, cand_skip, busy, done});
        end
        n_checks++;
        if ({sad, addr, amt} !== 28'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got sad=%0d addr=%0d amt=%0d want 0/0/0", sad, addr, amt);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({row_ready, reset_sum, comp_en, cand_skip, busy, done} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_strobes: got %b want 000000",
                     {row_ready, reset_sum, comp_en, cand_skip, busy, done});
        end
    endtask

    task automatic test_sweep;
        int ex[4] = '{0, 1, 0, 1};
        int ey[4] = '{0, 0, 1, 1};
        int cyc = 0;
        int last = 0;
        int k = 0;
        int rs = 0;
        bit fin = 1'b0;
        int exp_cyc;
        row_sad   = 12'd10;
        row_valid = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({reset_sum, busy, row_ready} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL sweep_clear: got rs/busy/rdy=%b want 110", {reset_sum, busy, row_ready});
        end
        tick();
        n_checks++;
        if ({reset_sum, row_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL sweep_first_ready: got rs/rdy=%b want 01", {reset_sum, row_ready});
        end
        for (int i = 0; i < 120 && !fin; i++) begin
            tick();
            cyc++;
            if (reset_sum) rs++;
            if (comp_en) begin
                exp_cyc = (k == 0) ? 16 : last + 17;
                n_checks++;
                if (cyc !== exp_cyc) begin
                    n_fail++;
                    $display("[TB] FAIL sweep_spacing: got cycle %0d want %0d", cyc, exp_cyc);
                end
                n_checks++;
                if (sad !== 16'd160) begin
                    n_fail++;
                    $display("[TB] FAIL sweep_sad: got %0d want 160", sad);
                end
                if (k < 4) begin
                    n_checks++;
                    if (addr !== 6'(ex[k]) || amt !== 6'(ey[k])) begin
                        n_fail++;
                        $display("[TB] FAIL sweep_pos: got (%0d,%0d) want (%0d,%0d)", addr, amt, ex[k], ey[k]);
                    end
                end
                last = cyc;
                k++;
            end
            if (done) begin
                fin = 1'b1;
                n_checks++;
                if (cyc !== last + 1 || k !== 4) begin
                    n_fail++;
                    $display("[TB] FAIL sweep_done: got cycle %0d after %0d pulses want cycle %0d after 4",
                             cyc, k, last + 1);
                end
            end
        end
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("[TB] FAIL sweep_timeout: got no done want done");
        end
        n_checks++;
        if (rs !== 0) begin
            n_fail++;
            $display("[TB] FAIL sweep_extra_reset_sum: got %0d want 0", rs);
        end
        row_valid = 1'b0;
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL sweep_idle: got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] m_sum = '0;
        int m_rows = 0;
        int mx = 0;
        int my = 0;
        bit m_emit = 1'b0;
        bit fin = 1'b0;
        bit acc;
        bit prev;
        int emits = 0;
        row_valid = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 800 && !fin; i++) begin
            n_checks++;
            if (row_ready !== !m_emit) begin
                n_fail++;
                $display("[TB] FAIL bp_row_ready: got %b want %b", row_ready, !m_emit);
            end
            row_valid = 1'($urandom_range(0, 1));
            row_sad   = 12'($urandom_range(0, 4080));
            acc  = row_valid && !m_emit;
            prev = m_emit;
            tick();
            if (prev) begin
                m_emit = 1'b0;
                if (mx == 1 && my == 1) begin
                    fin = 1'b1;
                    n_checks++;
                    if (done !== 1'b1) begin
                        n_fail++;
                        $display("[TB] FAIL bp_done: got %b want 1", done);
                    end
                end else if (mx == 1) begin
                    mx = 0;
                    my++;
                end else begin
                    mx++;
                end
            end else if (acc) begin
                m_sum = m_sum + {4'd0, row_sad};
                m_rows++;
                if (m_rows == 16) begin
                    m_emit = 1'b1;
                    emits++;
                    n_checks++;
                    if (comp_en !== 1'b1 || sad !== m_sum || addr !== 6'(mx) || amt !== 6'(my)) begin
                        n_fail++;
                        $display("[TB] FAIL bp_emit: got en=%b sad=%0d (%0d,%0d) want en=1 sad=%0d (%0d,%0d)",
                                 comp_en, sad, addr, amt, m_sum, mx, my);
                    end
                    m_sum  = '0;
                    m_rows = 0;
                end
            end
        end
        n_checks++;
        if (!fin || emits !== 4) begin
            n_fail++;
            $display("[TB] FAIL bp_count: got done=%b emits=%0d want done=1 emits=4", fin, emits);
        end
        row_valid = 1'b0;
        tick();
    endtask

    task automatic test_max_value;
        int k = 0;
        bit fin = 1'b0;
        row_sad   = 12'd4080;
        row_valid = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 120 && !fin; i++) begin
            tick();
            if (comp_en) begin
                k++;
                n_checks++;
                if (sad !== 16'd65280) begin
                    n_fail++;
                    $display("[TB] FAIL max_sad: got %0d want 65280", sad);
                end
            end
            if (done) fin = 1'b1;
        end
        n_checks++;
        if (!fin || k !== 4) begin
            n_fail++;
            $display("[TB] FAIL max_count: got done=%b emits=%0d want done=1 emits=4", fin, k);
        end
        row_valid = 1'b0;
        tick();
    endtask

    task automatic test_early_term;
        int k = 0;
        int skips = 0;
        int first_skip = -1;
        int cyc = 0;
        int fa = -1;
        int fm = -1;
        bit fin = 1'b0;
        min_sad   = 16'd100;
        row_sad   = 12'd60;
        row_valid = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 150 && !fin; i++) begin
            tick();
            cyc++;
            if (cand_skip) begin
                skips++;
                if (first_skip < 0) first_skip = cyc;
                min_sad = 16'hFFFF;
            end
            if (comp_en) begin
                if (k == 0) begin
                    fa = int'(addr);
                    fm = int'(amt);
                end
                k++;
                n_checks++;
                if (sad !== 16'd960) begin
                    n_fail++;
                    $display("[TB] FAIL et_sad: got %0d want 960", sad);
                end
            end
            if (done) fin = 1'b1;
        end
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("[TB] FAIL et_timeout: got no done want done");
        end
`ifdef SAD_EARLY_TERM_EN
        n_checks++;
        if (skips !== 1 || first_skip !== 2 || k !== 3) begin
            n_fail++;
            $display("[TB] FAIL et_skip: got skips=%0d at %0d emits=%0d want skips=1 at 2 emits=3",
                     skips, first_skip, k);
        end
        n_checks++;
        if (fa !== 1 || fm !== 0) begin
            n_fail++;
            $display("[TB] FAIL et_advance: got (%0d,%0d) want (1,0)", fa, fm);
        end
`else
        n_checks++;
        if (skips !== 0 || k !== 4) begin
            n_fail++;
            $display("[TB] FAIL et_off: got skips=%0d emits=%0d want skips=0 emits=4", skips, k);
        end
        n_checks++;
        if (fa !== 0 || fm !== 0) begin
            n_fail++;
            $display("[TB] FAIL et_first_pos: got (%0d,%0d) want (0,0)", fa, fm);
        end
`endif
        min_sad   = 16'hFFFF;
        row_valid = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset;
        int emits = 0;
        int seen_busy = 0;
        int rs = 0;
        bit fin = 1'b0;
        row_sad   = 12'd5;
        row_valid = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (5) tick();
        n_checks++;
        if ({busy, row_ready} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL mr_running: got busy/rdy=%b want 11", {busy, row_ready});
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({busy, row_ready, comp_en} !== 3'b000 || sad !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL mr_idle: got busy/rdy/en=%b sad=%0d want 000 sad=0",
                     {busy, row_ready, comp_en}, sad);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (comp_en) emits++;
            if (busy) seen_busy++;
        end
        n_checks++;
        if (emits !== 0 || seen_busy !== 0) begin
            n_fail++;
            $display("[TB] FAIL mr_quiet: got emits=%0d busy_cycles=%0d want 0/0", emits, seen_busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 120 && !fin; i++) begin
            if (reset_sum) rs++;
            if (comp_en) begin
                emits++;
                n_checks++;
                if (sad !== 16'd80) begin
                    n_fail++;
                    $display("[TB] FAIL mr_sad: got %0d want 80", sad);
                end
            end
            if (done) fin = 1'b1;
            tick();
        end
        n_checks++;
        if (rs !== 0 || emits !== 4 || !fin) begin
            n_fail++;
            $display("[TB] FAIL mr_ignored_start: got reset_sum=%0d emits=%0d done=%b want 0/4/1",
                     rs, emits, fin);
        end
        row_valid = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_max_value();
        test_early_term();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/me_sad_accum.md
# me_sad_accum

Row-serial SAD accumulator and candidate sequencer for the integer motion-estimation path. It accepts one 16-pixel row SAD per handshake from the absolute-difference array and sums ROWS rows per candidate. For each candidate it presents the full-block SAD with its (x, y) search position to the downstream min-SAD comparator as a one-cycle `comp_en` strobe. It also issues the comparator's `reset_sum` at the start of every macroblock search and walks the whole search window in raster order.

## Interface
- `ROWS`, 16: rows accumulated per candidate (2..16).
- `X_LAST`, 32: last horizontal candidate index, inclusive (0..63).
- `Y_LAST`, 32: last vertical candidate index, inclusive (0..63).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a macroblock search. Ignored while `busy`.
- `row_sad`, in, 12: SAD of one 16-pixel row (max 4080).
- `row_valid`, in, 1: `row_sad` is valid.
- `row_ready`, out, 1: block accepts a row this cycle.
- `min_sad`, in, 16: current best SAD from the comparator. Used only with early termination.
- `reset_sum`, out, 1: one-cycle clear pulse to the comparator.
- `comp_en`, out, 1: one-cycle strobe; `sad`, `addr` and `amt` are valid.
- `sad`, out, 16: full-block SAD of the candidate.
- `addr`, out, 6: candidate x index.
- `amt`, out, 6: candidate y index.
- `cand_skip`, out, 1: one-cycle pulse; the current candidate was abandoned.
- `busy`, out, 1: search in progress.
- `done`, out, 1: one-cycle pulse after the last candidate.

## Operation
- States: IDLE, CLEAR, ACCUM, EMIT, SKIP, DONE.
- IDLE:
  - `start` → CLEAR.
  - Row counter, accumulator, x and y are zeroed.
- CLEAR (1 cycle): `reset_sum`=1, `busy`=1 → ACCUM.
- ACCUM:
  - `row_ready`=1.
  - Each `row_valid & row_ready` adds `row_sad` (zero-extended) to the 16-bit accumulator and increments the row counter.
  - No saturation is needed: 16×4080 = 65280 fits in 16 bits.
  - Acceptance of row ROWS-1 → EMIT.
- EMIT (1 cycle):
  - `comp_en`=1; `sad` = final sum; `addr` = x; `amt` = y; `row_ready`=0.
  - The accumulator and row counter clear.
  - Candidate advance: x increments; when x = `X_LAST`, x wraps to 0 and y increments.
  - If x = `X_LAST` and y = `Y_LAST` → DONE, else → ACCUM.
- SKIP (1 cycle, early termination only):
  - `cand_skip`=1, `row_ready`=0, no `comp_en`.
  - Same clear, advance and DONE rules as EMIT.
- DONE (1 cycle): `done`=1, `busy`=0 on exit → IDLE.
- `sad`, `addr` and `amt` hold their last values outside EMIT.
- `busy`=1 in every state except IDLE.
- `start` asserted in any state other than IDLE has no effect.
- `row_valid` with `row_ready`=0 is not consumed. The upstream stage holds the row.

## Timing
- Reset values: `row_ready`, `reset_sum`, `comp_en`, `cand_skip`, `busy`, `done` = 0; `sad`=0, `addr`=0, `amt`=0; state = IDLE.
- `rst_n` low in any state returns the block to IDLE at that edge and drops all strobes. The partial sum is discarded.
- `start` sampled at edge N gives `reset_sum`=1 in cycle N+1; `row_ready` first rises in cycle N+2.
- With `row_valid` held high, a candidate occupies ROWS+1 cycles: ROWS accept cycles plus one EMIT cycle.
- `comp_en` is asserted in the cycle immediately after the last row is accepted.
- The comparator updates `min_sad` at the end of the EMIT cycle, so the next candidate's first row sees the updated value.
- All outputs are registered. There is no combinational path from any input to any output except `row_ready`, which is a state decode.
- `done` follows the final EMIT or SKIP by exactly one cycle.

## Configuration
- `SAD_EARLY_TERM_EN` defined:
  - When a row is accepted in ACCUM with row index < ROWS-1 and (accumulator + `row_sad`) ≥ `min_sad` (unsigned, 16-bit compare), the next state is SKIP instead of ACCUM.
  - The upstream stage must start the next candidate's rows after seeing `cand_skip`.
  - Acceptance of the last row always goes to EMIT, whatever the compare result.
- `SAD_EARLY_TERM_EN` undefined:
  - `min_sad` is ignored, `cand_skip` is constant 0 and SKIP is unreachable.
  - Every candidate produces exactly one `comp_en`.

## Test plan
- Reset and idle check: hold `rst_n`=0 for 3 cycles, then release with `start`=0. All outputs stay 0 and `row_ready`=0.
- Single-window sweep: `X_LAST`=1, `Y_LAST`=1, `ROWS`=16, `row_valid` held high, `row_sad`=10. Required: one `reset_sum` pulse; 4 `comp_en` pulses with `sad`=160 and (`addr`,`amt`) = (0,0),(1,0),(0,1),(1,1), spaced 17 cycles apart; `done` one cycle after the 4th pulse.
- Backpressure and gaps: toggle `row_valid` randomly at 50%. The sums stay exactly equal to the sum of accepted rows, and the `comp_en` count is unchanged.
- Maximum value: `row_sad`=4080 on every row gives `sad`=65280 with no wrap.
- Early termination (macro on): `min_sad`=100, `row_sad`=60. `cand_skip` pulses after the 2nd row (120 ≥ 100), with no `comp_en` for that candidate and x advancing. With the macro off, the same stimulus gives `comp_en` with `sad`=960.
- Mid-operation reset and ignored start: pull `rst_n` low after 5 rows, then return high. Required: IDLE, `busy`=0, and no `comp_en` until a new `start`. Separately, a `start` pulse during ACCUM causes no second `reset_sum`.
